// File: rtl/router_pkg.sv
// ============================================================================
// Module  : router_pkg
// Purpose : Shared router types and port-index constants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int PORT_LOCAL = 0;
  localparam int PORT_N     = 1;
  localparam int PORT_E     = 2;
  localparam int PORT_S     = 3;
  localparam int PORT_W     = 4;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational round-robin picker, one-hot at first request after last.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter  int N  = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick
);

  logic [IW-1:0] idx;
  logic          found;

  // Walk the ring starting just after the previous owner; first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = last;
    for (int k = 0; k < N; k++) begin
      idx = (idx == IW'(N - 1)) ? '0 : idx + IW'(1);
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_port_arbiter.sv
// ============================================================================
// Module  : output_port_arbiter
// Purpose : Packet-granular round-robin arbiter feeding a one-entry output
//           register. Optional lock timeout enabled by ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module output_port_arbiter
  import router_pkg::*;
#(
  parameter int N_PORTS = 5,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_PORTS-1:0]              in_req,
  input  logic [N_PORTS-1:0][WIDTH-1:0]   in_data,
  input  logic [N_PORTS-1:0]              in_tail,
  output logic [N_PORTS-1:0]              in_ack,
  output logic                            out_req,
  output logic [WIDTH-1:0]                out_data,
  output logic                            out_tail,
  input  logic                            out_ack,
  output logic [N_PORTS-1:0]              grant,
  output logic                            err_timeout
);

  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  arb_state_t         state;
  logic [IW-1:0]      last;
  logic [IW-1:0]      owner;
  logic [N_PORTS-1:0] pick;
  logic               out_free;
  logic               xfer;
  logic               xfer_tail;
  logic               hit;

  rr_pick #(.N(N_PORTS)) u_rr_pick (
    .req  (in_req),
    .last (last),
    .pick (pick)
  );

  always_comb begin
    owner = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) owner = IW'(i);
    end
  end

  // Accept only when the output register is empty or draining this cycle,
  // and never on the cycle the lock is being forcibly dropped.
  assign out_free  = !out_req || out_ack;
  assign in_ack    = (state == LOCKED && out_free && !hit) ? grant : '0;
  assign xfer      = |(in_req & in_ack);
  assign xfer_tail = xfer && in_tail[owner];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] idle_cnt;

  assign hit         = (state == LOCKED) && (idle_cnt == CW'(TIMEOUT));
  assign err_timeout = hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state == IDLE || xfer) begin
      idle_cnt <= '0;
    end else if (!hit) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end
`else
  assign hit         = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      last  <= IW'(N_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|in_req) begin
            grant <= pick;
            state <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer_tail || hit) begin
            last  <= owner;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_req  <= 1'b0;
      out_data <= '0;
      out_tail <= 1'b0;
    end else if (xfer) begin
      out_req  <= 1'b1;
      out_data <= in_data[owner];
      out_tail <= in_tail[owner];
    end else if (out_ack) begin
      out_req  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
// ============================================================================
// Module  : tb_output_port_arbiter
// Purpose : Self-checking bench with a packet-level round-robin reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_port_arbiter;

  localparam int N   = 5;
  localparam int W   = 32;
  localparam int TMO = 8;
  localparam int TRN = 4096;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          in_req = '0;
  logic [N-1:0][W-1:0]   in_data = '0;
  logic [N-1:0]          in_tail = '0;
  logic [N-1:0]          in_ack;
  logic                  out_req;
  logic [W-1:0]          out_data;
  logic                  out_tail;
  logic                  out_ack = 1'b0;
  logic [N-1:0]          grant;
  logic                  err_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W:0] pq [N][$];
  logic [W:0] exp_q [$];
  int         owner_q [$];
  bit         own_chk = 1'b1;
  int         ack_mode = 0;
  int         bp_lo = 0;
  int         bp_hi = 0;
  bit         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  logic [N-1:0] tr_grant [TRN];
  logic         tr_oreq  [TRN];
  logic [W-1:0] tr_odata [TRN];
  logic         tr_otail [TRN];
  logic         tr_err   [TRN];

  output_port_arbiter #(.N_PORTS(N), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_req      (in_req),
    .in_data     (in_data),
    .in_tail     (in_tail),
    .in_ack      (in_ack),
    .out_req     (out_req),
    .out_data    (out_data),
    .out_tail    (out_tail),
    .out_ack     (out_ack),
    .grant       (grant),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic drive();
    logic [W:0] f;
    for (int p = 0; p < N; p++) begin
      if (pq[p].size() > 0) begin
        f = pq[p][0];
        in_req[p]  = 1'b1;
        in_tail[p] = f[W];
        in_data[p] = f[W-1:0];
      end else begin
        in_req[p]  = 1'b0;
        in_tail[p] = 1'b0;
        in_data[p] = '0;
      end
    end
  endtask

  task automatic set_ack();
    case (ack_mode)
      1:       out_ack = ($urandom_range(9, 0) < 7);
      2:       out_ack = !(cyc >= bp_lo && cyc < bp_hi);
      default: out_ack = 1'b1;
    endcase
  endtask

  task automatic add_flit(input int p, input logic tail, input logic [W-1:0] d);
    pq[p].push_back({tail, d});
  endtask

  task automatic add_packet(input int p, input int len);
    for (int i = 0; i < len; i++) add_flit(p, (i == len - 1), W'($urandom()));
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (pq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Packet-level reference: whole packets are granted in ring order starting
  // after the previous owner, skipping ports with nothing left to send.
  task automatic build_model();
    int idx [N];
    int last;
    bit any;
    logic [W:0] f;
    for (int p = 0; p < N; p++) idx[p] = 0;
    last = N - 1;
    exp_q.delete();
    owner_q.delete();
    do begin
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (last + k) % N;
        if (idx[p] < pq[p].size()) begin
          any = 1'b1;
          owner_q.push_back(p);
          do begin
            f = pq[p][idx[p]];
            exp_q.push_back(f);
            idx[p]++;
          end while (!f[W] && idx[p] < pq[p].size());
          last = p;
          break;
        end
      end
    end while (any);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < N; p++) pq[p].delete();
    exp_q.delete();
    owner_q.delete();
    drive();
    out_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    cyc        = 0;
    prev_stall = 1'b0;
    own_chk    = 1'b1;
    ack_mode   = 0;
  endtask

  task automatic start();
    build_model();
    drive();
    set_ack();
  endtask

  task automatic run(input int n, input bit stop_empty);
    logic [N-1:0] acked;
    logic [W:0]   f;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (cyc < TRN) begin
        tr_grant[cyc] = grant;
        tr_oreq[cyc]  = out_req;
        tr_odata[cyc] = out_data;
        tr_otail[cyc] = out_tail;
        tr_err[cyc]   = err_timeout;
      end
      if (prev_stall) begin
        n_cmp++;
        if (out_req !== 1'b1 || out_data !== prev_data) begin
          n_err++;
          $display("FAIL hold cyc=%0d: out_req=%b out_data=%h, required out_req=1 out_data=%h",
                   cyc, out_req, out_data, prev_data);
        end
      end
      if (out_req && !out_ack) begin
        n_cmp++;
        if (in_ack !== '0) begin
          n_err++;
          $display("FAIL stall_ack cyc=%0d: in_ack=%b, required 0", cyc, in_ack);
        end
      end
      n_cmp++;
      if ((in_ack & ~grant) !== '0) begin
        n_err++;
        $display("FAIL ack_owner cyc=%0d: in_ack=%b grant=%b, required in_ack within grant",
                 cyc, in_ack, grant);
      end
      if (out_req && out_ack) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_flit cyc=%0d: got %b/%h, required no flit", cyc, out_tail, out_data);
        end else begin
          f = exp_q.pop_front();
          if ({out_tail, out_data} !== f) begin
            n_err++;
            $display("FAIL flit cyc=%0d: got tail=%b data=%h, required tail=%b data=%h",
                     cyc, out_tail, out_data, f[W], f[W-1:0]);
          end
        end
      end
      if (own_chk && grant !== '0) begin
        n_cmp++;
        if (owner_q.size() == 0 || grant !== (N'(1) << owner_q[0])) begin
          n_err++;
          $display("FAIL grant cyc=%0d: grant=%b, required port %0d",
                   cyc, grant, (owner_q.size() == 0) ? -1 : owner_q[0]);
        end
      end
      acked = in_req & in_ack;
      if (own_chk && (acked & in_tail) != '0 && owner_q.size() > 0) void'(owner_q.pop_front());
      prev_stall = out_req && !out_ack;
      prev_data  = out_data;
      @(posedge clk);
      #1;
      for (int p = 0; p < N; p++) if (acked[p]) void'(pq[p].pop_front());
      drive();
      cyc++;
      set_ack();
      if (stop_empty && exp_q.size() == 0 && all_empty()) break;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in_req  = '1;
    in_tail = '1;
    out_ack = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_req !== 1'b0) begin n_err++; $display("FAIL rst_out_req: got %b, required 0", out_req); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL rst_out_data: got %h, required 0", out_data); end
    n_cmp++; if (out_tail !== 1'b0) begin n_err++; $display("FAIL rst_out_tail: got %b, required 0", out_tail); end
    n_cmp++; if (grant !== '0) begin n_err++; $display("FAIL rst_grant: got %b, required 0", grant); end
    n_cmp++; if (in_ack !== '0) begin n_err++; $display("FAIL rst_in_ack: got %b, required 0", in_ack); end
    n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b, required 0", err_timeout); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    add_flit(2, 1'b0, 32'h0000_00A1);
    add_flit(2, 1'b0, 32'h0000_00B2);
    add_flit(2, 1'b1, 32'h0000_00C3);
    start();
    run(8, 1'b0);
    n_cmp++; if (tr_oreq[1] !== 1'b0) begin n_err++; $display("FAIL single_lat: out_req c1=%b, required 0", tr_oreq[1]); end
    n_cmp++; if (tr_grant[1] !== 5'b00100) begin n_err++; $display("FAIL single_grant: c1=%b, required 00100", tr_grant[1]); end
    n_cmp++; if (tr_odata[2] !== 32'hA1) begin n_err++; $display("FAIL single_A: c2=%h, required a1", tr_odata[2]); end
    n_cmp++; if (tr_odata[3] !== 32'hB2) begin n_err++; $display("FAIL single_B: c3=%h, required b2", tr_odata[3]); end
    n_cmp++; if (tr_odata[4] !== 32'hC3 || tr_otail[4] !== 1'b1) begin
      n_err++; $display("FAIL single_C: c4=%h tail=%b, required c3 tail=1", tr_odata[4], tr_otail[4]);
    end
    n_cmp++; if (tr_grant[5] !== '0) begin n_err++; $display("FAIL single_release: c5=%b, required 0", tr_grant[5]); end
  endtask

  task automatic test_contention();
    do_reset();
    add_flit(0, 1'b0, 32'h0A);
    add_flit(0, 1'b1, 32'h0B);
    add_flit(3, 1'b0, 32'h3A);
    add_flit(3, 1'b1, 32'h3B);
    start();
    run(10, 1'b0);
    n_cmp++; if (tr_grant[1] !== 5'b00001) begin n_err++; $display("FAIL cont_first: c1=%b, required 00001", tr_grant[1]); end
    n_cmp++; if (tr_grant[3] !== '0) begin n_err++; $display("FAIL cont_bubble: c3=%b, required 0", tr_grant[3]); end
    n_cmp++; if (tr_grant[4] !== 5'b01000) begin n_err++; $display("FAIL cont_second: c4=%b, required 01000", tr_grant[4]); end
    n_cmp++; if (tr_odata[2] !== 32'h0A || tr_odata[3] !== 32'h0B || tr_odata[5] !== 32'h3A || tr_odata[6] !== 32'h3B) begin
      n_err++; $display("FAIL cont_order: %h %h %h %h, required 0a 0b 3a 3b",
                        tr_odata[2], tr_odata[3], tr_odata[5], tr_odata[6]);
    end
    n_cmp++; if (tr_oreq[4] !== 1'b0) begin n_err++; $display("FAIL cont_gap: out_req c4=%b, required 0", tr_oreq[4]); end
  endtask

  task automatic test_rotation();
    logic [N-1:0] e;
    do_reset();
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_packet(p, 1);
    start();
    run(24, 1'b0);
    for (int c = 0; c < 20; c++) begin
      e = (c % 2 == 1) ? (N'(1) << (((c - 1) / 2) % N)) : '0;
      n_cmp++;
      if (tr_grant[c] !== e) begin
        n_err++; $display("FAIL rotation c%0d: grant=%b, required %b", c, tr_grant[c], e);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    add_packet(1, 4);
    ack_mode = 2;
    bp_lo    = 3;
    bp_hi    = 7;
    start();
    run(40, 1'b1);
    n_cmp++; if (tr_odata[6] !== tr_odata[3] || tr_oreq[6] !== 1'b1) begin
      n_err++; $display("FAIL bp_stable: c6=%h req=%b, required %h req=1", tr_odata[6], tr_oreq[6], tr_odata[3]);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_lost: %0d flits undelivered, required 0", exp_q.size()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int p = 0; p < N; p++) begin
        int np;
        np = $urandom_range(3, 0);
        for (int k = 0; k < np; k++) add_packet(p, $urandom_range(4, 1));
      end
      ack_mode = 1;
      start();
      run(3000, 1'b1);
      n_cmp++;
      if (exp_q.size() != 0 || !all_empty()) begin
        n_err++; $display("FAIL random_drain round %0d: %0d flits outstanding, required 0", r, exp_q.size());
      end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    own_chk = 1'b0;
    add_flit(1, 1'b0, 32'h1111);
    add_flit(4, 1'b1, 32'h4444);
    start();
    run(16, 1'b0);
    n_cmp++; if (tr_err[9] !== 1'b0 || tr_err[11] !== 1'b0) begin
      n_err++; $display("FAIL tmo_early_late: c9=%b c11=%b, required 0 0", tr_err[9], tr_err[11]);
    end
    n_cmp++; if (tr_err[10] !== 1'b1) begin n_err++; $display("FAIL tmo_pulse: c10=%b, required 1", tr_err[10]); end
    n_cmp++; if (tr_grant[10] !== 5'b00010 || tr_grant[11] !== '0) begin
      n_err++; $display("FAIL tmo_release: c10=%b c11=%b, required 00010 0", tr_grant[10], tr_grant[11]);
    end
    n_cmp++; if (tr_grant[12] !== 5'b10000) begin n_err++; $display("FAIL tmo_next: c12=%b, required 10000", tr_grant[12]); end
  endtask
`else
  task automatic test_timeout();
    logic any_err;
    do_reset();
    own_chk = 1'b0;
    add_flit(1, 1'b0, 32'h1111);
    add_flit(4, 1'b1, 32'h4444);
    start();
    run(30, 1'b0);
    any_err = 1'b0;
    for (int c = 0; c < 30; c++) any_err = any_err | tr_err[c];
    n_cmp++; if (any_err !== 1'b0) begin n_err++; $display("FAIL notmo_err: got %b, required 0", any_err); end
    n_cmp++; if (tr_grant[29] !== 5'b00010) begin n_err++; $display("FAIL notmo_lock: c29=%b, required 00010", tr_grant[29]); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    add_packet(0, 4);
    start();
    run(3, 1'b0);
    n_cmp++; if (tr_oreq[2] !== 1'b1) begin n_err++; $display("FAIL mid_inflight: out_req c2=%b, required 1", tr_oreq[2]); end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_req !== 1'b0 || out_data !== '0 || out_tail !== 1'b0 || grant !== '0 || in_ack !== '0 || err_timeout !== 1'b0) begin
      n_err++; $display("FAIL mid_async: req=%b data=%h tail=%b grant=%b ack=%b err=%b, required all 0",
                        out_req, out_data, out_tail, grant, in_ack, err_timeout);
    end
    do_reset();
    add_packet(2, 1);
    add_packet(0, 1);
    start();
    run(8, 1'b0);
    n_cmp++; if (tr_grant[1] !== 5'b00001) begin n_err++; $display("FAIL mid_restart: c1=%b, required 00001", tr_grant[1]); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_drain: %0d outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
